// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared FSM state type and parameter limits for the UART
//               transmit arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam int c_NREQ_MIN     = 2;
    localparam int c_NREQ_MAX     = 8;
    localparam int c_MAXBURST_MIN = 1;
    localparam int c_MAXBURST_MAX = 15;

    // Wide enough for the largest legal burst, so the counter can hold MAXBURST itself.
    localparam int c_BURST_W = $clog2(c_MAXBURST_MAX + 1);

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational rotating first-set search: first set bit of req
//               at or above ptr, wrapping modulo NREQ.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any
);

    logic [PW:0]   w_idx;
    logic          w_found;
    logic [PW-1:0] w_winner;

    always_comb begin
        w_idx    = '0;
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(NREQ)) begin
                w_idx = w_idx - (PW+1)'(NREQ);
            end
            if (!w_found && req[w_idx[PW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[PW-1:0];
            end
        end
    end

    assign winner = w_winner;
    assign any    = w_found;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arb.sv
// ============================================================================
// Module      : uart_tx_arb
// Description : Round-robin byte arbiter feeding one shared UART transmitter,
//               with per-grant burst limit and packet-last handling.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DATABITS = 8,
    parameter int MAXBURST = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATABITS-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          ack,
    output logic                     tx_start,
    output logic [DATABITS-1:0]      tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     active
);

    localparam int c_PW = $clog2(NREQ);

    state_t                r_state;
    logic [c_PW-1:0]       r_ptr;
    logic [c_PW-1:0]       r_owner;
    logic [c_BURST_W-1:0]  r_burst;
    logic                  r_last;
    logic [DATABITS-1:0]   r_tx_data;
    logic                  r_tx_start;
    logic [NREQ-1:0]       r_ack;
    logic                  r_active;

    logic [c_PW-1:0]       w_winner;
    logic                  w_any;
    logic                  w_own_req;
    logic                  w_own_last;
    logic [DATABITS-1:0]   w_own_byte;
    logic [NREQ-1:0]       w_own_hot;
    logic [c_PW-1:0]       w_ptr_nxt;
    logic                  w_burst_ok;
    logic                  w_more;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (c_PW)
    ) u_rr_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    // Select the current owner's lane without variable-width part-selects.
    always_comb begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_own_byte = '0;
        w_own_hot  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == c_PW'(i)) begin
                w_own_req    = req[i];
                w_own_last   = req_last[i];
                w_own_byte   = req_data[i*DATABITS +: DATABITS];
                w_own_hot[i] = 1'b1;
            end
        end
    end

    assign w_ptr_nxt  = (r_owner == c_PW'(NREQ-1)) ? '0 : r_owner + 1'b1;
    assign w_burst_ok = (r_burst < c_BURST_W'(MAXBURST));
    assign w_more     = w_own_req && !r_last && w_burst_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_burst    <= '0;
            r_last     <= 1'b0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_ack      <= '0;
            r_active   <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_ack      <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_owner  <= w_winner;
                        r_burst  <= '0;
                        r_active <= 1'b1;
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (!w_own_req) begin
                        r_ptr    <= w_ptr_nxt;
                        r_active <= 1'b0;
                        r_state  <= IDLE;
                    end else if (!tx_busy) begin
                        r_tx_data  <= w_own_byte;
                        r_tx_start <= 1'b1;
                        r_ack      <= w_own_hot;
                        r_last     <= w_own_last;
                        if (w_burst_ok) begin
                            r_burst <= r_burst + 1'b1;
                        end
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    // Requests are only looked at on the tx_done cycle itself.
                    if (tx_done) begin
                        if (w_more) begin
                            r_state <= LOAD;
                        end else begin
                            r_ptr    <= w_ptr_nxt;
                            r_active <= 1'b0;
                            r_state  <= IDLE;
                        end
                    end
                end
                default: begin
                    r_active <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign owner    = r_owner;
    assign active   = r_active;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Self-checking bench for uart_tx_arb: requester queues, a
//               transmitter model and a grant-order model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arb;

    localparam int NREQ     = 4;
    localparam int DATABITS = 8;
    localparam int MAXBURST = 4;
    localparam int FRAME    = 3;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [NREQ-1:0]          req;
    logic [NREQ*DATABITS-1:0] req_data;
    logic [NREQ-1:0]          req_last;
    logic [NREQ-1:0]          ack;
    logic                     tx_start;
    logic [DATABITS-1:0]      tx_data;
    logic                     tx_busy;
    logic                     tx_done = 1'b0;
    logic [1:0]               owner;
    logic                     active;

    logic [7:0] mem_d [NREQ][16];
    logic       mem_l [NREQ][16];
    int         head  [NREQ] = '{default: 0};
    int         cnt   [NREQ] = '{default: 0};

    logic       busy_m = 1'b0;
    logic       busy_force = 1'b0;
    int         frame_left = 0;
    logic       frame_open = 1'b0;
    logic [7:0] frame_data = '0;
    logic       prev_start = 1'b0;
    logic [3:0] prev_ack = '0;

    int         exp_owner[$];
    logic [7:0] exp_data[$];
    int         glog[$];
    int         m_ptr = 0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .NREQ     (NREQ),
        .DATABITS (DATABITS),
        .MAXBURST (MAXBURST)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .owner    (owner),
        .active   (active)
    );

    always_comb begin
        req      = '0;
        req_data = '0;
        req_last = '0;
        for (int i = 0; i < NREQ; i++) begin
            req[i]              = (cnt[i] > 0);
            req_data[i*8 +: 8]  = mem_d[i][head[i] % 16];
            req_last[i]         = mem_l[i][head[i] % 16];
        end
    end

    assign tx_busy = busy_m | busy_force;

    task automatic fail_line(input string name, input logic [31:0] got, input logic [31:0] want);
        n_err++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) fail_line(name, got, want);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) begin
            head[i] = 0;
            cnt[i]  = 0;
        end
        exp_owner.delete();
        exp_data.delete();
        glog.delete();
    endtask

    task automatic add(input int r, input logic [7:0] d, input logic l);
        mem_d[r][head[r] + cnt[r]] = d;
        mem_l[r][head[r] + cnt[r]] = l;
        cnt[r]++;
    endtask

    // Grant order from the arbitration rules, assuming every queue is loaded
    // up front and each requester stays pending until its queue is empty.
    task automatic model_order();
        int c[NREQ];
        int h[NREQ];
        int p, w, b, j, total;
        logic fin;
        p = m_ptr;
        total = 0;
        for (int i = 0; i < NREQ; i++) begin
            c[i] = cnt[i];
            h[i] = head[i];
            total += c[i];
        end
        while (total > 0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                j = (p + k) % NREQ;
                if (w < 0 && c[j] > 0) w = j;
            end
            b = 0;
            do begin
                exp_owner.push_back(w);
                exp_data.push_back(mem_d[w][h[w]]);
                fin = mem_l[w][h[w]];
                h[w]++;
                c[w]--;
                total--;
                b++;
            end while (c[w] > 0 && !fin && b < MAXBURST);
            p = (w + 1) % NREQ;
        end
        m_ptr = p;
    endtask

    task automatic check_log(input string name, input int n, input int e[8]);
        chk({name, "_len"}, glog.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < glog.size()) chk(name, glog[k], e[k]);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        logic done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #1;
            done = (cnt[0] + cnt[1] + cnt[2] + cnt[3] == 0) && (exp_owner.size() == 0)
                   && !active && !busy_m;
        end
        chk({name, "_complete"}, done, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        frame_open = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_ptr = 0;
        clear_all();
    endtask

    // Transmitter model, requester pop on ack, and the per-cycle comparisons.
    initial begin
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            n_vec++;
            a_ack_onehot: assert ($onehot0(ack)) else fail_line("ack_onehot", ack, 0);
            n_vec++;
            a_start_1cyc: assert (!(prev_start && tx_start)) else fail_line("tx_start_width", tx_start, 0);
            n_vec++;
            a_ack_1cyc: assert (!(prev_ack != 0 && ack != 0)) else fail_line("ack_width", ack, 0);
            n_vec++;
            a_ack_pair: assert (tx_start ? (ack != 0) : (ack == 0)) else fail_line("ack_with_start", ack, tx_start);
            if (frame_open && !tx_start) begin
                n_vec++;
                a_data_stable: assert (tx_data === frame_data) else fail_line("tx_data_stable", tx_data, frame_data);
            end
            if (tx_start) begin
                glog.push_back(int'(owner));
                if (exp_owner.size() == 0) begin
                    n_vec++;
                    fail_line("unexpected_tx_start", owner, 0);
                end else begin
                    chk("grant_owner", owner, exp_owner[0]);
                    chk("grant_data", tx_data, exp_data[0]);
                    chk("grant_ack", ack, 32'd1 << exp_owner[0]);
                    void'(exp_owner.pop_front());
                    void'(exp_data.pop_front());
                end
                busy_m     = 1'b1;
                frame_left = FRAME;
                frame_data = tx_data;
                frame_open = 1'b1;
            end else if (busy_m) begin
                frame_left--;
                if (frame_left == 0) begin
                    busy_m     = 1'b0;
                    tx_done    = 1'b1;
                    frame_open = 1'b0;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] && cnt[i] > 0) begin
                    head[i]++;
                    cnt[i]--;
                end
            end
            prev_start = tx_start;
            prev_ack   = ack;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1);
    end

    initial begin
        logic ok;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_ack", ack, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_active", active, 0);
        chk("rst_owner", owner, 0);
        reset = 1'b0;
        clear_all();

        // Single requester: latency and data
        add(0, 8'hA5, 1'b1);
        model_order();
        @(posedge clk); #1;
        chk("single_active", active, 1);
        chk("single_owner", owner, 0);
        chk("single_no_start_c1", tx_start, 0);
        @(posedge clk); #1;
        chk("single_start_c2", tx_start, 1);
        chk("single_data", tx_data, 8'hA5);
        chk("single_ack", ack, 4'b0001);
        wait_done("single", 40);

        // Pointer advanced to 1
        clear_all();
        add(0, 8'h11, 1'b1);
        add(1, 8'h22, 1'b1);
        model_order();
        wait_done("ptr1", 60);
        check_log("ptr1_order", 2, '{1, 0, 0, 0, 0, 0, 0, 0});

        // Contention, one byte per grant
        do_reset();
        add(0, 8'h10, 1'b1);
        add(0, 8'h11, 1'b1);
        add(1, 8'h21, 1'b1);
        add(2, 8'h32, 1'b1);
        add(3, 8'h43, 1'b1);
        model_order();
        wait_done("contend", 150);
        check_log("contend_order", 5, '{0, 1, 2, 3, 0, 0, 0, 0});

        // Burst cap
        clear_all();
        for (int k = 0; k < 6; k++) add(2, 8'hC0 + 8'(k), 1'b0);
        add(0, 8'hD0, 1'b1);
        model_order();
        wait_done("burst", 200);
        check_log("burst_order", 7, '{2, 2, 2, 2, 0, 2, 2, 0});

        // Withdraw in LOAD
        clear_all();
        add(1, 8'h55, 1'b1);
        @(posedge clk); #1;
        chk("withdraw_owner", owner, 1);
        chk("withdraw_active", active, 1);
        cnt[1] = 0;
        @(posedge clk); #1;
        chk("withdraw_idle", active, 0);
        ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (tx_start) ok = 1'b0;
            @(posedge clk); #1;
        end
        chk("withdraw_no_start", ok, 1);
        m_ptr = 2;
        clear_all();
        add(1, 8'h61, 1'b1);
        add(2, 8'h62, 1'b1);
        model_order();
        wait_done("after_withdraw", 60);
        check_log("after_withdraw_order", 2, '{2, 1, 0, 0, 0, 0, 0, 0});

        // Transmitter busy holds LOAD
        clear_all();
        busy_force = 1'b1;
        add(3, 8'h5C, 1'b1);
        model_order();
        ok = 1'b1;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            if (tx_start) ok = 1'b0;
        end
        chk("busy_no_start", ok, 1);
        chk("busy_held_active", active, 1);
        busy_force = 1'b0;
        @(posedge clk); #1;
        chk("busy_release_start", tx_start, 1);
        chk("busy_release_data", tx_data, 8'h5C);
        chk("busy_release_owner", owner, 3);
        wait_done("busy", 40);

        // Reset mid-WAIT
        clear_all();
        add(2, 8'h7E, 1'b1);
        model_order();
        ok = 1'b0;
        for (int c = 0; c < 10 && !ok; c++) begin
            @(posedge clk); #1;
            ok = tx_start;
        end
        chk("midwait_start_seen", ok, 1);
        @(negedge clk); #1;
        reset = 1'b1;
        frame_open = 1'b0;
        #1;
        chk("midwait_rst_start", tx_start, 0);
        chk("midwait_rst_ack", ack, 0);
        chk("midwait_rst_active", active, 0);
        chk("midwait_rst_data", tx_data, 0);
        chk("midwait_rst_owner", owner, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_ptr = 0;
        ok = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (tx_start || active) ok = 1'b0;
        end
        chk("late_done_ignored", ok, 1);
        wait_done("midwait", 20);
        clear_all();
        add(3, 8'h93, 1'b1);
        add(0, 8'h90, 1'b1);
        model_order();
        wait_done("post_reset", 60);
        check_log("post_reset_order", 2, '{0, 3, 0, 0, 0, 0, 0, 0});

        chk("exp_queue_drained", exp_owner.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
